module_imem_responder: RTL and testbench
========================================

Name: module_imem_responder

Overview:
Instruction-memory responder: the serving end of the fetch interface driven by the program counter.
- Accepts fetch requests (address) via a valid/ready handshake.
- Reads a word-addressed instruction store and returns the instruction after a fixed pipeline latency through a small response FIFO.
- Flags misaligned/out-of-range fetches; supports a flush so that redirects (jumps/branches) discard stale fetches.
- Sits between module_program_counter/fetch stage and decode.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit instruction words stored (power of 2)
LATENCY, 2, cycles from request acceptance to entry into response FIFO (1..4)
RESP_DEPTH, 4, response FIFO depth; also the maximum number of outstanding requests (power of 2, >=2)
INIT_FILE, "", hex file loaded with $readmemh at time 0; empty string leaves memory at 0

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  fetch request present
req_ready  output  1  responder can accept request this cycle
req_addr  input  32  byte address of instruction
flush  input  1  discard all in-flight and queued fetches
resp_valid  output  1  response at FIFO head
resp_ready  input  1  consumer takes response
resp_addr  output  32  address the response belongs to
resp_instr  output  32  fetched instruction
resp_fault  output  1  1 = misaligned or out-of-range fetch

Behaviour:
- Reset (reset==0, async): pipeline valids, FIFO pointers and outstanding count cleared; req_ready=0 while asserted, 1 in the first cycle after release; resp_valid=0, resp_addr=0, resp_instr=0, resp_fault=0. Memory contents are not reset. Reset mid-operation drops everything.
- Accept: req_valid && req_ready at a rising edge. req_ready = (outstanding < RESP_DEPTH) && !flush. Combinational; does not depend on req_valid.
- outstanding counts entries in pipeline + FIFO:
  - +1 on accept, −1 on pop (resp_valid && resp_ready).
  - Both in the same cycle: unchanged.
  - The FIFO can never overflow.
- Latency: a request accepted at edge N appears at FIFO head at earliest edge N+LATENCY. resp_valid is asserted after edge N+LATENCY when the FIFO was empty. Back-to-back requests give one response per cycle when resp_ready=1.
- Fault: set if req_addr[1:0]!=0 or req_addr[31:2] >= DEPTH_WORDS. A faulted request has resp_instr=32'h00000013 (NOP), resp_fault=1, and still consumes a slot and is returned in order.
- Index: word index = req_addr[$clog2(DEPTH_WORDS)+1:2].
- Ordering: strict FIFO order. resp_addr echoes req_addr unchanged.
- Outputs: resp_* are registered FIFO-head values. They are held stable while resp_valid && !resp_ready.
- Flush: at the edge where flush=1, all pipeline valids, FIFO contents and outstanding are cleared. resp_valid=0 next cycle. No request is accepted in a flush cycle (req_ready=0). A pop coincident with flush completes but its entry is discarded anyway.
- Empty: resp_valid=0; resp_* hold the last values.
- Full: outstanding==RESP_DEPTH → req_ready=0 until a pop.
- Counter/pointer wrap modulo RESP_DEPTH via extra MSB for full/empty.

Optional Feature:
IMEM_LOAD_PORT_EN
- Defined: adds ports load_en (in, 1), load_addr (in, 32, byte address), load_data (in, 32). On a rising edge with load_en=1 and in-range, word-aligned load_addr, mem[load_addr[..:2]] <= load_data. Invalid load addresses are ignored.
- A fetch accepted in the same cycle as a load to the same word returns the old data. A fetch accepted the following cycle returns the new data.
- Not defined: ports absent; memory is read-only, initialised only from INIT_FILE.

Decomposition:
- Shared package imem_pkg: RISC-V NOP constant (32'h00000013), response struct typedef {addr[31:0], instr[31:0], fault}, fault-check function.
- One natural sub-module: module_resp_fifo (parameterised synchronous FIFO, async active-low reset, flush input, full/empty).
- Latency pipeline and memory stay in the top.

Test Plan:
- Reset released; INIT_FILE with mem[0]=32'h00500093; request addr 0 at edge N, resp_ready=1 → resp_valid=1 after edge N+2, resp_instr=32'h00500093, resp_addr=0, resp_fault=0.
- Back-to-back addresses 0,4,8,12 with resp_ready=1 → four consecutive valid responses in order, req_ready stays 1.
- resp_ready=0, issue 5 requests → req_ready=0 after the 4th accept. Release resp_ready for 1 cycle → exactly one pop, req_ready=1 for one more accept.
- Request addr 32'h2 and addr 4*1024 → resp_fault=1, resp_instr=32'h00000013, returned in order between good fetches.
- Three requests in flight, assert flush one cycle → resp_valid=0 next cycle, none of the three ever returned. Request addr 16 after flush → sole response with resp_addr=16.
- Assert reset low mid-stream with FIFO holding 2 entries → resp_valid=0, req_ready=0 immediately (async). After release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } resp_t;

  localparam int RESP_W = $bits(resp_t);

  // A fetch or load address is unusable if it is not word aligned or lies past the store.
  function automatic logic fetch_fault(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/module_resp_fifo.sv
// Response FIFO whose head is held in a register, so the outputs stay stable and keep the last value when empty.
module module_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [RESP_W-1:0] wdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [RESP_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [RESP_W-1:0] slot_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RESP_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = head_q;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    head_d  = head_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else if (wptr_q != rptr_d) begin
      // Entries remain in storage after this pop: the next one becomes the head.
      head_d = slot_q[rptr_d[AW-1:0]];
    end else if (do_push) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) slot_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/module_imem_responder.sv
// Instruction-memory responder: fetch requests in, in-order instruction responses out after LATENCY cycles.
// Define IMEM_LOAD_PORT_EN to add a write port (load_en/load_addr/load_data) into the instruction store.
module module_imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RESP_DEPTH  = 4,
  parameter     INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_addr,
  output logic [31:0] resp_instr,
  output logic        resp_fault
`ifdef IMEM_LOAD_PORT_EN
  ,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
`endif
);
  localparam int            IW           = $clog2(DEPTH_WORDS);
  localparam int            CW           = $clog2(RESP_DEPTH) + 1;
  localparam logic [CW-1:0] RESP_DEPTH_C = CW'(RESP_DEPTH);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic              vld_p_q [LATENCY];
  logic              vld_p_d [LATENCY];
  logic [RESP_W-1:0] dat_p_q [LATENCY];
  logic [RESP_W-1:0] dat_p_d [LATENCY];
  logic [CW-1:0]     outst_q, outst_d;
  logic              accept, pop, fetch_flt;
  logic              fifo_full, fifo_empty, fifo_push;
  logic [RESP_W-1:0] head_bits;
  resp_t             head, new_resp;

`ifdef IMEM_LOAD_PORT_EN
  // Fetches read the store at their accept edge, so a same-edge load is seen only by later fetches.
  always_ff @(posedge clock) begin
    if (load_en && !fetch_fault(load_addr, DEPTH_WORDS)) mem_q[load_addr[IW+1:2]] <= load_data;
  end
`endif

  assign req_ready  = reset && !flush && !fifo_full && (outst_q < RESP_DEPTH_C);
  assign accept     = req_valid && req_ready;
  assign resp_valid = !fifo_empty;
  assign pop        = resp_valid && resp_ready;

  always_comb begin
    fetch_flt      = fetch_fault(req_addr, DEPTH_WORDS);
    new_resp.addr  = req_addr;
    new_resp.fault = fetch_flt;
    new_resp.instr = fetch_flt ? NOP_INSTR : mem_q[req_addr[IW+1:2]];
  end

  always_comb begin
    vld_p_d[0] = accept;
    dat_p_d[0] = new_resp;
    for (int i = 1; i < LATENCY; i++) begin
      vld_p_d[i] = vld_p_q[i-1];
      dat_p_d[i] = dat_p_q[i-1];
    end
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) vld_p_d[i] = 1'b0;
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (flush)               outst_d = '0;
    else if (accept && !pop) outst_d = outst_q + CW'(1);
    else if (pop && !accept) outst_d = outst_q - CW'(1);
  end

  // Stage p0 captures the read at the accept edge; the last stage feeds the response FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) vld_p_q[i] <= 1'b0;
      outst_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) vld_p_q[i] <= vld_p_d[i];
      outst_q <= outst_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < LATENCY; i++) dat_p_q[i] <= dat_p_d[i];
  end

  assign fifo_push = vld_p_q[LATENCY-1] && !flush;

  module_resp_fifo #(
    .DEPTH(RESP_DEPTH)
  ) u_resp_fifo (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .push (fifo_push),
    .wdata(dat_p_q[LATENCY-1]),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head_bits)
  );

  assign head       = resp_t'(head_bits);
  assign resp_addr  = head.addr;
  assign resp_instr = head.instr;
  assign resp_fault = head.fault;

endmodule

// File: tb/tb_module_imem_responder.sv
// Randomised scoreboard bench for module_imem_responder (default parameters, load port disabled).
module tb_module_imem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int RDEP  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_addr;
  logic [31:0] resp_instr;
  logic        resp_fault;

  module_imem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .RESP_DEPTH (RDEP),
    .INIT_FILE  ("")
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_addr (resp_addr),
    .resp_instr(resp_instr),
    .resp_fault(resp_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [DEPTH];
  logic [31:0] last_addr = '0, last_instr = '0;
  logic        last_fault = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    int          m = $urandom_range(0, 9);
    logic [31:0] a = 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (m == 7)      a = a + 32'($urandom_range(1, 3));
    else if (m == 8) a = a + 32'(4 * DEPTH);
    else if (m == 9) a = $urandom;
    return a;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor / scoreboard: sampled on the falling edge, reflecting what the next rising edge will do.
  always @(negedge clock) begin
    logic exp_ready, exp_valid;
    exp_t e;
    if (!reset) begin
      chk("req_ready_in_reset", 32'(req_ready), 32'd0);
      chk("resp_valid_in_reset", 32'(resp_valid), 32'd0);
      chk("resp_addr_in_reset", resp_addr, 32'd0);
      chk("resp_instr_in_reset", resp_instr, 32'd0);
      sb.delete();
      last_addr = '0; last_instr = '0; last_fault = 1'b0;
    end else begin
      exp_ready = (sb.size() < RDEP) && !flush;
      exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
      if (resp_valid && sb.size() > 0) begin
        chk("resp_addr", resp_addr, sb[0].addr);
        chk("resp_instr", resp_instr, sb[0].instr);
        chk("resp_fault", 32'(resp_fault), 32'(sb[0].fault));
        last_addr = sb[0].addr; last_instr = sb[0].instr; last_fault = sb[0].fault;
      end else if (resp_valid) begin
        chk("unexpected_response_addr", resp_addr, 32'hxxxx_xxxx);
      end else begin
        chk("hold_addr", resp_addr, last_addr);
        chk("hold_instr", resp_instr, last_instr);
        chk("hold_fault", 32'(resp_fault), 32'(last_fault));
      end
      if (resp_valid && resp_ready && sb.size() > 0) void'(sb.pop_front());
      if (flush) sb.delete();
      if (req_valid && exp_ready) begin
        e.addr  = req_addr;
        e.fault = exp_fault(req_addr);
        e.instr = e.fault ? 32'h0000_0013 : mem_model[req_addr >> 2];
        e.due   = cyc + 1 + LAT;
        sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [31:0] a);
    int   n  = 0;
    logic ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    do begin
      @(negedge clock);
      ok = req_ready;
      tick();
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = $urandom;
    mem_model[0] = 32'h0050_0093;
    for (int i = 0; i < DEPTH; i++) dut.mem_q[i] = mem_model[i];
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // single fetch of word 0
    resp_ready = 1'b1;
    send(32'h0);
    repeat (5) tick();

    // back-to-back fetches
    send(32'h0); send(32'h4); send(32'h8); send(32'hC);
    repeat (6) tick();

    // fill to capacity, then a single pop frees one slot
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h40 + 32'(4 * i));
    req_valid = 1'b1;
    req_addr  = 32'h50;
    repeat (4) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    send(32'h50);
    repeat (3) tick();
    resp_ready = 1'b1;
    repeat (8) tick();

    // faulting fetches interleaved with good ones
    send(32'h10); send(32'h2); send(32'h1000); send(32'h14);
    repeat (6) tick();

    // flush discards everything in flight
    resp_ready = 1'b0;
    send(32'h20); send(32'h24); send(32'h28);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    resp_ready = 1'b1;
    repeat (4) tick();
    send(32'h10);
    repeat (5) tick();

    // asynchronous reset with two responses queued
    resp_ready = 1'b0;
    send(32'h30); send(32'h34);
    repeat (4) tick();
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("async_reset_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    resp_ready = 1'b1;
    repeat (8) tick();

    // randomised traffic with backpressure and occasional flushes
    for (int i = 0; i < 800; i++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_addr   = rand_addr();
      resp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 39) == 0);
      tick();
    end
    req_valid  = 1'b0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    repeat (12) tick();
    chk("drain_leftover", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
